eth_udp_tx_gmii: RTL and testbench
==================================

Name: eth_udp_tx_gmii

Overview:
- UDP/IPv4 frame transmitter on a GMII interface; the transmit counterpart of the GMII UDP receive path.
- Builds the complete frame from the latched addresses and payload length: preamble/SFD, Ethernet header, IPv4 header with computed checksum, UDP header, payload pulled byte-by-byte from an upstream FIFO, zero padding, FCS, inter-frame gap.
- Sits between the user payload FIFO and the PHY GMII TX pins, clocked by the local 125 MHz clock.

Parameters:
- ETH_TYPE, 16'h0800, EtherType field.
- IP_TTL, 8'h40, IPv4 TTL field.
- IFG_BYTES, 12, idle cycles appended after the FCS.
- VLAN_TAG, 16'h0001, PCP/DEI/VID word; used only with ETH_TX_VLAN_EN.

Ports:
- clk125m  in  1  125 MHz TX clock.
- reset_p  in  1  asynchronous reset, active high.
- local_mac  in  48  source MAC.
- local_ip  in  32  source IP.
- local_port  in  16  source UDP port.
- dst_mac  in  48  destination MAC.
- dst_ip  in  32  destination IP.
- dst_port  in  16  destination UDP port.
- data_length  in  16  payload bytes, 0..1472.
- tx_start  in  1  single-cycle request pulse.
- tx_busy  out  1  frame in progress.
- tx_done  out  1  single-cycle pulse at end of frame.
- payload_req_o  out  1  FIFO read strobe.
- payload_dat_i  in  8  FIFO data, valid the cycle after payload_req_o.
- gmii_tx_clk  out  1  forwarded clk125m.
- gmii_txen  out  1  registered GMII TX enable.
- gmii_txd  out  8  registered GMII TX data.

Behaviour:
- Clock and reset: clk125m; reset reset_p, asynchronous, active-high.
- Reset values: tx_busy=0, tx_done=0, payload_req_o=0, gmii_txen=0, gmii_txd=0, ip_id=0, state=IDLE.
- Reset mid-frame: gmii_txen falls immediately; no tx_done is issued.
- Start: tx_start is honoured only in IDLE and while tx_busy=0; it is ignored otherwise.
- On acceptance (edge N):
  - latch all address inputs.
  - latch len = min(data_length, 1472).
  - tx_busy rises.
  - cycle N+1 (CHECKSUM state): the IPv4 header checksum is computed over the latched fields.
  - the first preamble byte appears with gmii_txen=1 at edge N+2.
- FSM states: IDLE -> CHECKSUM -> TX_PREAMBLE -> TX_ETH_HEADER -> TX_IP_HEADER -> TX_UDP_HEADER -> TX_DATA -> TX_PAD -> TX_CRC -> TX_IFG -> IDLE. Transitions are count-driven.
- TX_PREAMBLE: 7 bytes of 0x55, then 0xD5.
- TX_ETH_HEADER: 14 bytes: dst_mac, local_mac, ETH_TYPE, all MSB-first.
- TX_IP_HEADER: 20 bytes:
  - 0x45, tos 0x00.
  - total_len = len+28.
  - ip_id.
  - flags/frag 0x4000.
  - IP_TTL, protocol 0x11.
  - checksum.
  - local_ip, dst_ip.
- Checksum: one's-complement sum of the 16-bit header words with carries folded twice, then inverted.
- ip_id increments by 1 (mod 2^16) after each completed frame.
- TX_UDP_HEADER: 8 bytes: local_port, dst_port, udp_len = len+8, checksum 0x0000.
- TX_DATA: exactly len bytes.
  - payload_req_o asserts on the cycle before each byte is driven, so its first assertion is the last UDP-header cycle.
  - It is asserted for exactly len cycles per frame.
  - len=0 skips TX_DATA entirely.
- TX_PAD: entered when len<18; drives 18-len bytes of 0x00.
- TX_CRC: 4 FCS bytes.
  - CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) covers the destination MAC through the last pad byte.
  - The result is complemented and transmitted low byte first.
- TX_IFG: gmii_txen=0 and gmii_txd=0 for IFG_BYTES cycles. tx_done pulses on the final IFG cycle; tx_busy falls on the same edge.
- gmii_txen is continuous (no gaps) from preamble through the last FCS byte.
- gmii_tx_clk = clk125m, passed straight through.

Optional Feature:
- Macro ETH_TX_VLAN_EN.
- Defined:
  - after the source MAC, insert 0x8100 followed by VLAN_TAG (4 bytes, included in the CRC).
  - then ETH_TYPE.
  - pad rule unchanged (pad to 18 payload bytes).
  - frame grows by 4 bytes.
- Undefined: no tag and no related logic.

Test Plan:
- len=100, all addresses set, FIFO counting 0x00.. -> gmii_txen high for 154 contiguous cycles.
  - bytes 0-7 are 55×7, D5.
  - IP total_len 0x0080, UDP len 0x006C.
  - payload 0x00..0x63.
  - receiver-side CRC residue is 0x2144DF1C.
  - payload_req_o asserted exactly 100 cycles.
- len=0 -> 72 txen cycles, 18 zero pad bytes, zero payload_req_o pulses, total_len 0x001C.
- len=18 then len=17 -> both 72 txen cycles; the second frame has 1 pad byte.
- Two back-to-back frames, with tx_start re-pulsed while busy:
  - the pulse during busy is ignored.
  - ip_id goes 0x0000 then 0x0001.
  - at least 12 idle cycles between frames.
  - header checksum verified against a software model.
- Assert reset_p during TX_DATA -> gmii_txen=0 the same cycle, no tx_done; a subsequent frame is correct with ip_id restarted at 0.
- With ETH_TX_VLAN_EN, len=100 -> 158 txen cycles, bytes 20-23 = 81 00 00 01, and the CRC residue is still 0x2144DF1C.

Source files
------------

// File: rtl/eth_udp_tx_gmii.sv
// UDP/IPv4 frame transmitter for GMII TX: header build, IPv4 checksum, payload, pad, FCS, IFG.
// Optional ETH_TX_VLAN_EN inserts an 802.1Q tag (0x8100 + VLAN_TAG) after the source MAC.
module eth_udp_tx_gmii #(
  parameter logic [15:0] ETH_TYPE  = 16'h0800,
  parameter logic [7:0]  IP_TTL    = 8'h40,
`ifdef ETH_TX_VLAN_EN
  parameter logic [15:0] VLAN_TAG  = 16'h0001,
`endif
  parameter int unsigned IFG_BYTES = 12
) (
  input  logic        clk125m,
  input  logic        reset_p,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic [15:0] local_port,
  input  logic [47:0] dst_mac,
  input  logic [31:0] dst_ip,
  input  logic [15:0] dst_port,
  input  logic [15:0] data_length,
  input  logic        tx_start,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        payload_req_o,
  input  logic [7:0]  payload_dat_i,
  output logic        gmii_tx_clk,
  output logic        gmii_txen,
  output logic [7:0]  gmii_txd
);

`ifdef ETH_TX_VLAN_EN
  localparam int unsigned ETH_LEN = 18;
`else
  localparam int unsigned ETH_LEN = 14;
`endif
  localparam int unsigned ETH_BITS = ETH_LEN * 8;

  localparam logic [3:0] IDLE          = 4'd0;
  localparam logic [3:0] CHECKSUM      = 4'd1;
  localparam logic [3:0] TX_PREAMBLE   = 4'd2;
  localparam logic [3:0] TX_ETH_HEADER = 4'd3;
  localparam logic [3:0] TX_IP_HEADER  = 4'd4;
  localparam logic [3:0] TX_UDP_HEADER = 4'd5;
  localparam logic [3:0] TX_DATA       = 4'd6;
  localparam logic [3:0] TX_PAD        = 4'd7;
  localparam logic [3:0] TX_CRC        = 4'd8;
  localparam logic [3:0] TX_IFG        = 4'd9;

  logic [3:0]  state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] len_q;
  logic [47:0] dst_mac_q, src_mac_q;
  logic [31:0] dst_ip_q, src_ip_q;
  logic [15:0] dst_port_q, src_port_q;
  logic [15:0] ip_id_q, csum_q;
  logic [31:0] crc_q;
  logic        busy_q, done_q, txen_q;
  logic [7:0]  txd_q;

  logic        accept, last_ifg, tx_active, crc_en;
  logic [7:0]  tx_byte;
  logic [15:0] total_len, udp_len, csum_calc;
  logic [19:0] csum_acc;
  logic [16:0] csum_f1, csum_f2;
  logic [ETH_BITS-1:0] eth_hdr, eth_sh;
  logic [159:0] ip_hdr, ip_sh;
  logic [63:0]  udp_hdr, udp_sh;
  logic [31:0]  crc_sh;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign accept    = (state_q == IDLE) && !busy_q && tx_start;
  assign last_ifg  = (state_q == TX_IFG) && (cnt_q == 11'(IFG_BYTES - 1));
  assign tx_active = (state_q >= TX_PREAMBLE) && (state_q <= TX_CRC);
  assign crc_en    = (state_q >= TX_ETH_HEADER) && (state_q <= TX_PAD);

  assign total_len = {5'd0, len_q} + 16'd28;
  assign udp_len   = {5'd0, len_q} + 16'd8;

`ifdef ETH_TX_VLAN_EN
  assign eth_hdr = {dst_mac_q, src_mac_q, 16'h8100, VLAN_TAG, ETH_TYPE};
`else
  assign eth_hdr = {dst_mac_q, src_mac_q, ETH_TYPE};
`endif
  assign ip_hdr  = {8'h45, 8'h00, total_len, ip_id_q, 16'h4000, IP_TTL, 8'h11, csum_q,
                    src_ip_q, dst_ip_q};
  assign udp_hdr = {src_port_q, dst_port_q, udp_len, 16'h0000};

  // 9 words fit in 20 bits; two folds absorb every possible carry.
  always_comb begin
    csum_acc = 20'(16'h4500) + 20'(total_len) + 20'(ip_id_q) + 20'(16'h4000)
             + 20'({IP_TTL, 8'h11}) + 20'(src_ip_q[31:16]) + 20'(src_ip_q[15:0])
             + 20'(dst_ip_q[31:16]) + 20'(dst_ip_q[15:0]);
    csum_f1   = 17'(csum_acc[15:0]) + 17'(csum_acc[19:16]);
    csum_f2   = 17'(csum_f1[15:0]) + 17'(csum_f1[16]);
    csum_calc = ~csum_f2[15:0];
  end

  always_comb begin
    eth_sh  = eth_hdr << {cnt_q[4:0], 3'b000};
    ip_sh   = ip_hdr << {cnt_q[4:0], 3'b000};
    udp_sh  = udp_hdr << {cnt_q[2:0], 3'b000};
    crc_sh  = ~crc_q >> {cnt_q[1:0], 3'b000};
    tx_byte = 8'h00;
    case (state_q)
      TX_PREAMBLE:   tx_byte = (cnt_q == 11'd7) ? 8'hD5 : 8'h55;
      TX_ETH_HEADER: tx_byte = eth_sh[ETH_BITS-1 -: 8];
      TX_IP_HEADER:  tx_byte = ip_sh[159:152];
      TX_UDP_HEADER: tx_byte = udp_sh[63:56];
      TX_DATA:       tx_byte = payload_dat_i;
      TX_CRC:        tx_byte = crc_sh[7:0];
      default:       tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 11'd1;
    case (state_q)
      IDLE: begin
        cnt_d = 11'd0;
        if (accept) state_d = CHECKSUM;
      end
      CHECKSUM: begin
        state_d = TX_PREAMBLE;
        cnt_d   = 11'd0;
      end
      TX_PREAMBLE: if (cnt_q == 11'd7) begin
        state_d = TX_ETH_HEADER;
        cnt_d   = 11'd0;
      end
      TX_ETH_HEADER: if (cnt_q == 11'(ETH_LEN - 1)) begin
        state_d = TX_IP_HEADER;
        cnt_d   = 11'd0;
      end
      TX_IP_HEADER: if (cnt_q == 11'd19) begin
        state_d = TX_UDP_HEADER;
        cnt_d   = 11'd0;
      end
      TX_UDP_HEADER: if (cnt_q == 11'd7) begin
        state_d = (len_q == 11'd0) ? TX_PAD : TX_DATA;
        cnt_d   = 11'd0;
      end
      TX_DATA: if (cnt_q == len_q - 11'd1) begin
        state_d = (len_q < 11'd18) ? TX_PAD : TX_CRC;
        cnt_d   = 11'd0;
      end
      TX_PAD: if (cnt_q == 11'd17 - len_q) begin
        state_d = TX_CRC;
        cnt_d   = 11'd0;
      end
      TX_CRC: if (cnt_q == 11'd3) begin
        state_d = TX_IFG;
        cnt_d   = 11'd0;
      end
      TX_IFG: if (last_ifg) begin
        state_d = IDLE;
        cnt_d   = 11'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 11'd0;
      end
    endcase
  end

  // Request one cycle ahead so FIFO data is present when the byte is registered.
  assign payload_req_o = ((state_q == TX_UDP_HEADER) && (cnt_q == 11'd7) && (len_q != 11'd0)) ||
                         ((state_q == TX_DATA) && (cnt_q != len_q - 11'd1));

  always_ff @(posedge clk125m or posedge reset_p) begin
    if (reset_p) begin
      state_q <= IDLE;
      cnt_q   <= 11'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      txen_q  <= 1'b0;
      txd_q   <= 8'h00;
      ip_id_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      txen_q  <= tx_active;
      txd_q   <= tx_byte;
      done_q  <= last_ifg;
      if (accept) begin
        busy_q <= 1'b1;
      end else if (last_ifg) begin
        busy_q <= 1'b0;
      end
      if (last_ifg) ip_id_q <= ip_id_q + 16'd1;
    end
  end

  always_ff @(posedge clk125m) begin
    if (accept) begin
      dst_mac_q  <= dst_mac;
      src_mac_q  <= local_mac;
      dst_ip_q   <= dst_ip;
      src_ip_q   <= local_ip;
      dst_port_q <= dst_port;
      src_port_q <= local_port;
      len_q      <= (data_length > 16'd1472) ? 11'd1472 : data_length[10:0];
    end
    if (state_q == CHECKSUM) begin
      csum_q <= csum_calc;
      crc_q  <= 32'hFFFFFFFF;
    end else if (crc_en) begin
      crc_q <= crc32_byte(crc_q, tx_byte);
    end
  end

  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign gmii_txen   = txen_q;
  assign gmii_txd    = txd_q;
  assign gmii_tx_clk = clk125m;

endmodule

// File: tb/tb_eth_udp_tx_gmii.sv
// Bench for eth_udp_tx_gmii: frame-level byte model, per-cycle wire compare, literal pins.
module tb_eth_udp_tx_gmii;
`ifdef ETH_TX_VLAN_EN
  localparam int ETH_LEN = 18;
`else
  localparam int ETH_LEN = 14;
`endif
  localparam int H = 8 + ETH_LEN;  // offset of IPv4 header in captured frame

  logic        clk125m = 1'b0;
  logic        reset_p = 1'b1;
  logic [47:0] local_mac = 48'h0200_0000_0001;
  logic [31:0] local_ip = 32'hC0A8_010A;
  logic [15:0] local_port = 16'h1234;
  logic [47:0] dst_mac = 48'hA0B1_C2D3_E4F5;
  logic [31:0] dst_ip = 32'hC0A8_0114;
  logic [15:0] dst_port = 16'h5678;
  logic [15:0] data_length = 16'd0;
  logic        tx_start = 1'b0;
  logic        tx_busy, tx_done, payload_req_o, gmii_tx_clk, gmii_txen;
  logic [7:0]  payload_dat_i = 8'h00;
  logic [7:0]  gmii_txd;

  eth_udp_tx_gmii dut (
    .clk125m(clk125m), .reset_p(reset_p),
    .local_mac(local_mac), .local_ip(local_ip), .local_port(local_port),
    .dst_mac(dst_mac), .dst_ip(dst_ip), .dst_port(dst_port),
    .data_length(data_length), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
    .payload_req_o(payload_req_o), .payload_dat_i(payload_dat_i),
    .gmii_tx_clk(gmii_tx_clk), .gmii_txen(gmii_txen), .gmii_txd(gmii_txd)
  );

  always #4 clk125m = ~clk125m;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cap[$];
  logic [7:0] mf[$];
  int req_cnt = 0;
  int done_cnt = 0;
  int last_run = -1;
  logic [7:0] fifo_next = 8'h00;
  logic [15:0] model_id = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if ((r[0] ^ b[i]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
      else r = r >> 1;
    end
    return r;
  endfunction

  task automatic push_be(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) mf.push_back(v[8*i +: 8]);
  endtask

  function automatic int frame_len(input int len);
    return 54 + ETH_LEN - 14 + ((len < 18) ? 18 : len);
  endfunction

  // Expected wire bytes for one frame, from preamble to last FCS byte.
  task automatic build_frame(input int dlen);
    int len;
    int sum;
    logic [15:0] csum;
    logic [31:0] crc;
    len = (dlen > 1472) ? 1472 : dlen;
    mf = {};
    for (int i = 0; i < 7; i++) mf.push_back(8'h55);
    mf.push_back(8'hD5);
    push_be(dst_mac, 6);
    push_be(local_mac, 6);
`ifdef ETH_TX_VLAN_EN
    push_be(48'h8100, 2);
    push_be(48'h0001, 2);
`endif
    push_be(48'h0800, 2);
    sum = 'h4500 + (len + 28) + int'(model_id) + 'h4000 + 'h4011
        + int'(local_ip[31:16]) + int'(local_ip[15:0]) + int'(dst_ip[31:16]) + int'(dst_ip[15:0]);
    while (sum > 'hFFFF) sum = (sum & 'hFFFF) + (sum >> 16);
    csum = ~sum[15:0];
    push_be(48'h4500, 2);
    push_be(48'(len + 28), 2);
    push_be({32'd0, model_id}, 2);
    push_be(48'h4000, 2);
    push_be(48'h4011, 2);
    push_be({32'd0, csum}, 2);
    push_be({16'd0, local_ip}, 4);
    push_be({16'd0, dst_ip}, 4);
    push_be({32'd0, local_port}, 2);
    push_be({32'd0, dst_port}, 2);
    push_be(48'(len + 8), 2);
    push_be(48'h0, 2);
    for (int i = 0; i < len; i++) mf.push_back(8'(i));
    for (int i = len; i < 18; i++) mf.push_back(8'h00);
    crc = 32'hFFFFFFFF;
    for (int i = 8; i < mf.size(); i++) crc = crc_step(crc, mf[i]);
    crc = ~crc;
    for (int i = 0; i < 4; i++) mf.push_back(crc[8*i +: 8]);
    foreach (mf[i]) exp_q.push_back(mf[i]);
  endtask

  function automatic logic [31:0] residue();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 8; i < cap.size(); i++) c = crc_step(c, cap[i]);
    return ~c;
  endfunction

  // Upstream FIFO: data for a request appears in the following cycle.
  initial begin
    logic r;
    forever begin
      @(negedge clk125m);
      r = payload_req_o;
      @(posedge clk125m);
      #1;
      if (r) begin
        payload_dat_i = fifo_next;
        fifo_next = fifo_next + 8'd1;
      end
    end
  end

  // Wire compare against the model on every cycle.
  initial begin
    logic prev;
    logic seen;
    int run;
    int gap;
    logic [7:0] e;
    prev = 1'b0; seen = 1'b0; run = 0; gap = 0;
    forever begin
      @(negedge clk125m);
      if (reset_p) begin
        prev = 1'b0; run = 0; gap = 0;
        continue;
      end
      if (payload_req_o) req_cnt++;
      if (tx_done) done_cnt++;
      if (gmii_txen) begin
        if (!prev && seen) check("ifg_gap_ge_12", 32'(gap >= 12), 32'd1);
        cap.push_back(gmii_txd);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h, expected no transmission", gmii_txd);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("byte%0d", cap.size() - 1), {24'd0, gmii_txd}, {24'd0, e});
        end
        run++;
      end else begin
        if (prev) begin
          last_run = run; run = 0; gap = 0; seen = 1'b1;
        end
        gap++;
        check("idle_txd", {24'd0, gmii_txd}, 32'd0);
      end
      prev = gmii_txen;
    end
  end

  task automatic start_frame(input int dlen);
    @(negedge clk125m);
    data_length = 16'(dlen);
    fifo_next = 8'h00;
    req_cnt = 0;
    cap = {};
    last_run = -1;
    build_frame(dlen);
    tx_start = 1'b1;
    @(posedge clk125m);
    #1 tx_start = 1'b0;
    check("busy_on_accept", {31'd0, tx_busy}, 32'd1);
    @(posedge clk125m);
    #1 check("txen_low_at_n1", {31'd0, gmii_txen}, 32'd0);
    @(posedge clk125m);
    #1 check("txen_high_at_n2", {31'd0, gmii_txen}, 32'd1);
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(negedge clk125m);
      if (tx_done) begin
        got = 1'b1;
        check("busy_falls_with_done", {31'd0, tx_busy}, 32'd0);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL tx_done_timeout: got no tx_done, expected one within 5000 cycles");
    end else begin
      model_id = model_id + 16'd1;
    end
  endtask

  task automatic finish_frame(input int len);
    check("txen_run_len", 32'(last_run), 32'(frame_len(len)));
    check("payload_req_cycles", 32'(req_cnt), 32'(len));
    check("model_bytes_left", 32'(exp_q.size()), 32'd0);
    check("crc_residue", residue(), 32'h2144DF1C);
  endtask

  initial begin
    #1;
    check("rst_txen", {31'd0, gmii_txen}, 32'd0);
    check("rst_txd", {24'd0, gmii_txd}, 32'd0);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    check("rst_req", {31'd0, payload_req_o}, 32'd0);
    #20;
    @(negedge clk125m) reset_p = 1'b0;
    repeat (3) @(negedge clk125m);

    // len 100, with a start pulse during busy that must be ignored
    start_frame(100);
    repeat (20) @(negedge clk125m);
    tx_start = 1'b1;
    @(negedge clk125m) tx_start = 1'b0;
    wait_done();
    finish_frame(100);
    check("run_len_literal", 32'(last_run), 32'(154 + ETH_LEN - 14));
    check("preamble_lo", {cap[0], cap[1], cap[2], cap[3]}, 32'h55555555);
    check("preamble_hi", {cap[4], cap[5], cap[6], cap[7]}, 32'h555555D5);
    check("total_len", {16'd0, cap[H+2], cap[H+3]}, 32'h0080);
    check("ip_id_first", {16'd0, cap[H+4], cap[H+5]}, 32'h0000);
    check("ip_csum_literal", {16'd0, cap[H+10], cap[H+11]}, 32'hB6FE);
    check("udp_len", {16'd0, cap[H+24], cap[H+25]}, 32'h006C);
    check("payload_first", {24'd0, cap[H+28]}, 32'h00);
    check("payload_last", {24'd0, cap[H+127]}, 32'h63);
`ifdef ETH_TX_VLAN_EN
    check("vlan_tag", {cap[20], cap[21], cap[22], cap[23]}, 32'h81000001);
`endif

    // back-to-back second frame
    start_frame(30);
    wait_done();
    finish_frame(30);
    check("ip_id_second", {16'd0, cap[H+4], cap[H+5]}, 32'h0001);
    repeat (30) @(negedge clk125m);

    start_frame(0);
    wait_done();
    finish_frame(0);
    check("len0_total_len", {16'd0, cap[H+2], cap[H+3]}, 32'h001C);
    begin
      logic [7:0] acc;
      acc = 8'h00;
      for (int i = 0; i < 18; i++) acc = acc | cap[H+28+i];
      check("len0_pad_zero", {24'd0, acc}, 32'd0);
    end

    start_frame(18);
    wait_done();
    finish_frame(18);
    start_frame(17);
    wait_done();
    finish_frame(17);
    check("len17_udp_len", {16'd0, cap[H+24], cap[H+25]}, 32'h0019);

    // reset in the middle of the payload
    start_frame(100);
    for (int i = 0; i < 3000 && req_cnt < 10; i++) @(negedge clk125m);
    check("reached_payload", 32'(req_cnt >= 10), 32'd1);
    begin
      int d0;
      d0 = done_cnt;
      @(posedge clk125m);
      #2 reset_p = 1'b1;
      #1;
      check("txen_async_reset", {31'd0, gmii_txen}, 32'd0);
      check("busy_async_reset", {31'd0, tx_busy}, 32'd0);
      exp_q = {};
      repeat (3) @(negedge clk125m);
      reset_p = 1'b0;
      model_id = 16'h0000;
      repeat (20) @(negedge clk125m);
      check("no_done_after_abort", 32'(done_cnt), 32'(d0));
    end
    start_frame(50);
    wait_done();
    finish_frame(50);
    check("ip_id_after_reset", {16'd0, cap[H+4], cap[H+5]}, 32'h0000);
    repeat (20) @(negedge clk125m);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
